// File: rtl/flag_branch_unit.sv
// Condition-flag register file and conditional branch resolver with a saturating taken-branch counter.
// Optional build macro FLAG_BYPASS_EN: same-cycle flag writes are forwarded into branch evaluation.
module flag_branch_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_zr,
    input  logic        alu_ov,
    input  logic        alu_ne,
    input  logic        wr_zr,
    input  logic        wr_vn,
    output logic        old_zr,
    output logic        old_ov,
    output logic        old_ne,
    input  logic        br_valid,
    output logic        br_ready,
    input  logic [2:0]  br_cond,
    input  logic [15:0] br_pc,
    input  logic [8:0]  br_off,
    output logic        br_done,
    output logic        br_taken,
    output logic [15:0] br_target,
    output logic        flush,
    output logic [15:0] taken_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next;

    logic                r_zr;
    logic                r_ov;
    logic                r_ne;

    logic [2:0]          r_cond;
    logic [15:0]         r_pc;
    logic signed [8:0]   r_off;

    logic                r_taken;
    logic [15:0]         r_target;
    logic [15:0]         r_taken_cnt;

    logic                w_eval_now;
    logic                w_eval_wait;
    logic                w_capture;
    logic                w_ez;
    logic                w_ev;
    logic                w_en;
    logic [2:0]          w_cond;
    logic [15:0]         w_pc;
    logic signed [8:0]   w_off;
    logic                w_taken;

    function automatic logic cond_true(input logic [2:0] c, input logic z,
                                       input logic v, input logic n);
        logic t;
        case (c)
            3'd0:    t = !z;
            3'd1:    t = z;
            3'd2:    t = !z && !n;
            3'd3:    t = n;
            3'd4:    t = !n;
            3'd5:    t = n || z;
            3'd6:    t = v;
            default: t = 1'b1;
        endcase
        return t;
    endfunction

    function automatic logic [15:0] branch_target(input logic [15:0] pc,
                                                  input logic signed [8:0] off);
        logic signed [15:0] off_ext;
        off_ext = 16'(off);
        return pc + 16'($unsigned(off_ext));
    endfunction

    // Flag registers: writes are accepted in every FSM state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_zr <= 1'b0;
            r_ov <= 1'b0;
            r_ne <= 1'b0;
        end else begin
            if (wr_zr) begin
                r_zr <= alu_zr;
            end
            if (wr_vn) begin
                r_ov <= alu_ov;
                r_ne <= alu_ne;
            end
        end
    end

    assign old_zr = r_zr;
    assign old_ov = r_ov;
    assign old_ne = r_ne;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        br_ready    = 1'b0;
        br_done     = 1'b0;
        w_eval_now  = 1'b0;
        w_eval_wait = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            IDLE: begin
                br_ready = 1'b1;
                if (br_valid) begin
`ifdef FLAG_BYPASS_EN
                    w_eval_now = 1'b1;
                    w_next     = DONE;
`else
                    // A flag write in the accept cycle must land before evaluation
                    if (wr_zr || wr_vn) begin
                        w_capture = 1'b1;
                        w_next    = WAIT;
                    end else begin
                        w_eval_now = 1'b1;
                        w_next     = DONE;
                    end
`endif
                end
            end
            WAIT: begin
                w_eval_wait = 1'b1;
                w_next      = DONE;
            end
            DONE: begin
                br_done = 1'b1;
                w_next  = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Forwarding mux only matters on an accept that carries a flag write
    assign w_ez = (w_eval_now && wr_zr) ? alu_zr : r_zr;
    assign w_ev = (w_eval_now && wr_vn) ? alu_ov : r_ov;
    assign w_en = (w_eval_now && wr_vn) ? alu_ne : r_ne;

    assign w_cond  = w_eval_wait ? r_cond : br_cond;
    assign w_pc    = w_eval_wait ? r_pc   : br_pc;
    assign w_off   = w_eval_wait ? r_off  : $signed(br_off);
    assign w_taken = cond_true(w_cond, w_ez, w_ev, w_en);

    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_cond <= br_cond;
            r_pc   <= br_pc;
            r_off  <= $signed(br_off);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_taken  <= 1'b0;
            r_target <= 16'h0000;
        end else if (w_eval_now || w_eval_wait) begin
            r_taken  <= w_taken;
            r_target <= w_taken ? branch_target(w_pc, w_off) : w_pc;
        end
    end

    assign br_taken  = r_taken;
    assign br_target = r_target;
    assign flush     = br_done & r_taken;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_taken_cnt <= 16'h0000;
        end else if (flush && (r_taken_cnt != 16'hFFFF)) begin
            r_taken_cnt <= r_taken_cnt + 16'd1;
        end
    end

    assign taken_cnt = r_taken_cnt;

endmodule

// File: tb/tb_flag_branch_unit.sv
// Self-checking bench for flag_branch_unit: directed steps then randomized branches against a reference model.
module tb_flag_branch_unit;

    logic        clk;
    logic        rst;
    logic        alu_zr;
    logic        alu_ov;
    logic        alu_ne;
    logic        wr_zr;
    logic        wr_vn;
    logic        old_zr;
    logic        old_ov;
    logic        old_ne;
    logic        br_valid;
    logic        br_ready;
    logic [2:0]  br_cond;
    logic [15:0] br_pc;
    logic [8:0]  br_off;
    logic        br_done;
    logic        br_taken;
    logic [15:0] br_target;
    logic        flush;
    logic [15:0] taken_cnt;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    bit          mz;
    bit          mv;
    bit          mn;
    bit [15:0]   mcnt;
    bit          last_t;
    bit [15:0]   last_tg;

    flag_branch_unit dut (
        .clk       (clk),
        .rst       (rst),
        .alu_zr    (alu_zr),
        .alu_ov    (alu_ov),
        .alu_ne    (alu_ne),
        .wr_zr     (wr_zr),
        .wr_vn     (wr_vn),
        .old_zr    (old_zr),
        .old_ov    (old_ov),
        .old_ne    (old_ne),
        .br_valid  (br_valid),
        .br_ready  (br_ready),
        .br_cond   (br_cond),
        .br_pc     (br_pc),
        .br_off    (br_off),
        .br_done   (br_done),
        .br_taken  (br_taken),
        .br_target (br_target),
        .flush     (flush),
        .taken_cnt (taken_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "bench did not finish");
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit m_cond(input bit [2:0] c, input bit z, input bit v, input bit n);
        if (c == 3'd0) return !z;
        if (c == 3'd1) return z;
        if (c == 3'd2) return !z && !n;
        if (c == 3'd3) return n;
        if (c == 3'd4) return !n;
        if (c == 3'd5) return n || z;
        if (c == 3'd6) return v;
        return 1'b1;
    endfunction

    task automatic check_flags(input string tag);
        chk1({tag, "_z"}, old_zr, mz);
        chk1({tag, "_v"}, old_ov, mv);
        chk1({tag, "_n"}, old_ne, mn);
    endtask

    task automatic drive_flags(input bit wz, input bit az, input bit wvn,
                               input bit av, input bit an);
        wr_zr  = wz;
        alu_zr = az;
        wr_vn  = wvn;
        alu_ov = av;
        alu_ne = an;
        if (wz) mz = az;
        if (wvn) begin
            mv = av;
            mn = an;
        end
    endtask

    task automatic idle_write(input bit wz, input bit az, input bit wvn,
                              input bit av, input bit an);
        drive_flags(wz, az, wvn, av, an);
        @(negedge clk);
        drive_flags(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_flags("idle_wr");
    endtask

    // Issues one branch from an IDLE negedge and follows it until the unit is ready again.
    task automatic do_branch(input bit [2:0] c, input bit [15:0] pc, input bit [8:0] off,
                             input bit wz, input bit az, input bit wvn, input bit av,
                             input bit an, input bit noise);
        bit        hz;
        bit        exp_t;
        bit [15:0] exp_tg;
        int        offi;
        int        lat;
        chk1("ready_pre", br_ready, 1'b1);
        br_valid = 1'b1;
        br_cond  = c;
        br_pc    = pc;
        br_off   = off;
        drive_flags(wz, az, wvn, av, an);
        hz     = wz | wvn;
        exp_t  = m_cond(c, mz, mv, mn);
        offi   = off[8] ? int'(off) - 512 : int'(off);
        exp_tg = exp_t ? 16'(int'(pc) + offi) : pc;
`ifdef FLAG_BYPASS_EN
        lat = 1;
`else
        lat = hz ? 2 : 1;
`endif
        @(negedge clk);
        for (int cyc = 1; cyc <= lat + 1; cyc++) begin
            check_flags("br_flags");
            chk16("cnt", taken_cnt, mcnt);
            if (cyc < lat) begin
                chk1("wait_done", br_done, 1'b0);
                chk1("wait_ready", br_ready, 1'b0);
                chk1("wait_flush", flush, 1'b0);
            end else if (cyc == lat) begin
                chk1("done", br_done, 1'b1);
                chk1("done_ready", br_ready, 1'b0);
                chk1("taken", br_taken, exp_t);
                chk16("target", br_target, exp_tg);
                chk1("flush", flush, exp_t);
                if (exp_t && mcnt != 16'hFFFF) mcnt = mcnt + 16'd1;
            end else begin
                chk1("post_done", br_done, 1'b0);
                chk1("post_flush", flush, 1'b0);
                chk1("post_ready", br_ready, 1'b1);
                chk1("hold_taken", br_taken, exp_t);
                chk16("hold_target", br_target, exp_tg);
            end
            if (cyc <= lat && noise) begin
                br_valid = 1'($urandom_range(0, 1));
                br_cond  = 3'($urandom);
                br_pc    = 16'($urandom);
                br_off   = 9'($urandom);
                drive_flags(1'($urandom), 1'($urandom), 1'($urandom),
                            1'($urandom), 1'($urandom));
            end else begin
                br_valid = 1'b0;
                drive_flags(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            end
            if (cyc <= lat) @(negedge clk);
        end
        last_t  = exp_t;
        last_tg = exp_tg;
    endtask

    task automatic preload_cnt(input logic [15:0] v);
        force dut.r_taken_cnt = v;
        #1;
        release dut.r_taken_cnt;
        mcnt = v;
    endtask

    // Accept a taken branch, then pulse rst in the following cycle.
    task automatic reset_mid(input bit hazard);
        br_valid = 1'b1;
        br_cond  = 3'd7;
        br_pc    = 16'h4000;
        br_off   = 9'h010;
        drive_flags(hazard, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        br_valid = 1'b0;
        drive_flags(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mz = 1'b0; mv = 1'b0; mn = 1'b0; mcnt = 16'h0000;
        chk1("rst_done", br_done, 1'b0);
        chk1("rst_flush", flush, 1'b0);
        chk1("rst_ready", br_ready, 1'b1);
        chk1("rst_taken", br_taken, 1'b0);
        chk16("rst_target", br_target, 16'h0000);
        chk16("rst_cnt", taken_cnt, 16'h0000);
        check_flags("rst_flags");
        @(negedge clk);
        chk1("rst_done2", br_done, 1'b0);
        chk1("rst_flush2", flush, 1'b0);
        chk16("rst_cnt2", taken_cnt, 16'h0000);
    endtask

    initial begin
        rst = 1'b1;
        br_valid = 1'b0;
        br_cond = 3'd0;
        br_pc = 16'h0000;
        br_off = 9'h000;
        drive_flags(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        mz = 1'b0; mv = 1'b0; mn = 1'b0; mcnt = 16'h0000;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_flags("reset");
        chk1("reset_ready", br_ready, 1'b1);
        chk1("reset_done", br_done, 1'b0);
        chk1("reset_taken", br_taken, 1'b0);
        chk16("reset_target", br_target, 16'h0000);
        chk1("reset_flush", flush, 1'b0);
        chk16("reset_cnt", taken_cnt, 16'h0000);

        // Z write only; V/N values offered but not enabled
        idle_write(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);

        // EQ taken with negative offset
        do_branch(3'd1, 16'h0010, 9'h1F0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk16("eq_target", last_tg, 16'h0000);
        chk16("eq_cnt", taken_cnt, 16'h0001);

        // Clear Z, then LT not taken
        idle_write(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        do_branch(3'd3, 16'h1234, 9'h055, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk1("lt_taken", last_t, 1'b0);

        // Same-cycle hazard: Z written to 1 with an EQ branch
        do_branch(3'd1, 16'h0100, 9'h020, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk1("haz_taken", last_t, 1'b1);

        // Hazard with V/N write feeding OVFL and LT
        do_branch(3'd6, 16'h0200, 9'h004, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        do_branch(3'd3, 16'h0300, 9'h1FF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);

        // Target wraps past 16'hFFFF
        do_branch(3'd7, 16'hFFFF, 9'h002, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk16("wrap_target", last_tg, 16'h0001);

        // Saturation of the taken counter
        preload_cnt(16'hFFFE);
        chk16("preload_cnt", taken_cnt, 16'hFFFE);
        do_branch(3'd7, 16'h0040, 9'h001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk16("sat_reach", taken_cnt, 16'hFFFF);
        do_branch(3'd7, 16'h0050, 9'h0FF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk16("sat_hold", taken_cnt, 16'hFFFF);

        // Reset while a result is pending (DONE), then while a hazard is pending
        reset_mid(1'b0);
        do_branch(3'd0, 16'h0A00, 9'h100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset_mid(1'b1);

        // Randomized branches, flag traffic and ignored requests while busy
        for (int it = 0; it < 120; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                idle_write(1'($urandom), 1'($urandom), 1'($urandom),
                           1'($urandom), 1'($urandom));
            end
            do_branch(3'($urandom), 16'($urandom), 9'($urandom),
                      1'($urandom_range(0, 2) == 0), 1'($urandom),
                      1'($urandom_range(0, 2) == 0), 1'($urandom), 1'($urandom),
                      1'b1);
            if (it == 60) preload_cnt(16'hFFF0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/flag_branch_unit.md
# flag_branch_unit

Holds the processor's condition flags (Z, V, N) written by the ALU, returns them to the ALU as its "old" flag inputs, and resolves conditional branches against them. Sits between EX (flag producer) and the fetch/PC logic (branch consumer). Each accepted branch produces a one-cycle result pulse carrying the taken decision, the 16-bit target, and a flush request. A taken-branch statistics counter is also maintained.

## Interface
- No parameters; datapath fixed at 16 bits, offset 9 bits.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- alu_zr, alu_ov, alu_ne  in  1 each  flag values from ALU this cycle.
- wr_zr  in  1  write Z this cycle (ALU op active).
- wr_vn  in  1  write V and N this cycle (add/sub).
- old_zr, old_ov, old_ne  out  1 each  current flag registers, fed back to ALU.
- br_valid  in  1  branch request present.
- br_ready  out  1  unit can accept a request.
- br_cond  in  3  condition code.
- br_pc  in  16  PC+1 of branch.
- br_off  in  9  signed word offset.
- br_done  out  1  one-cycle result strobe.
- br_taken  out  1  condition true; valid when br_done.
- br_target  out  16  next PC; valid when br_done.
- flush  out  1  br_done & br_taken.
- taken_cnt  out  16  count of taken branches, saturating.

## Operation
- Flags: Z <= alu_zr when wr_zr; V <= alu_ov and N <= alu_ne when wr_vn; otherwise hold. old_* = registers.
- Conditions on (Z,V,N): 000 NE !Z; 001 EQ Z; 010 GT !Z&!N; 011 LT N; 100 GTE !N; 101 LTE N|Z; 110 OVFL V; 111 UNCOND 1.
- Target: taken → br_pc + sign_extend(br_off) mod 2^16; not taken → br_pc.
- Accept = br_valid & br_ready; request fields captured on accept.
- FSM states IDLE, WAIT, DONE:
  - IDLE: br_ready=1. Accept with no flag write (wr_zr=wr_vn=0) → evaluate on current flags → DONE. Accept with a flag write in the same cycle → hazard (see Configuration).
  - WAIT: br_ready=0; evaluate captured request on the registered flags, which include the write from the accept cycle → DONE. Flag writes during WAIT update registers but are younger than the branch and are ignored for its evaluation.
  - DONE: br_done=1, outputs driven from result registers, br_ready=0 → IDLE.
- taken_cnt increments on each cycle with flush=1; holds at 16'hFFFF.
- Flag writes are never blocked by the FSM state.

## Timing
- Reset: Z=V=N=0, state IDLE, br_done=0, br_taken=0, br_target=16'h0000, flush=0, taken_cnt=0, br_ready=1 in the cycle after reset.
- A flag write at edge k is visible on old_* in cycle k+1.
- No hazard: accept at edge k → br_done high during cycle k+1 → br_ready high again in cycle k+2. Minimum spacing between accepts is 2 cycles.
- Hazard without bypass: accept at edge k → WAIT in cycle k+1 → br_done in cycle k+2.
- br_taken and br_target hold their last values after br_done falls; flush is only ever a 1-cycle pulse.
- rst asserted in WAIT or DONE: request dropped, br_done/flush forced 0 in the following cycle, taken_cnt not incremented.
- br_valid without br_ready: ignored; the requester must hold the request.

## Configuration
- FLAG_BYPASS_EN defined: on a hazard accept in IDLE, each flag used for evaluation is taken from alu_* where its write enable is set, and from the register otherwise. FSM goes directly to DONE; the latency is the same as the no-hazard case. WAIT is unreachable.
- FLAG_BYPASS_EN undefined: a hazard accept goes through WAIT, adding one cycle.
- Flag register behaviour is identical in both builds.

## Test plan
- Reset, then check Z=V=N=0, br_ready=1, taken_cnt=0. Next, wr_zr=1 with alu_zr=1 → old_zr=1 the next cycle, while old_ov and old_ne remain 0.
- Z=1, EQ branch, br_pc=16'h0010, br_off=9'h1F0 (-16) → br_done one cycle after accept, br_taken=1, br_target=16'h0000, flush=1, taken_cnt=1.
- N=0, Z=0, LT branch, br_pc=16'h1234 → br_taken=0, br_target=16'h1234, flush=0.
- Same-cycle hazard: Z=0, wr_zr=1 with alu_zr=1, EQ branch accepted. With FLAG_BYPASS_EN → taken, br_done at k+1. Without it → taken, br_done at k+2, and br_ready=0 during cycles k+1 and k+2.
- Wrap: br_pc=16'hFFFF, br_off=9'h002, UNCOND → br_target=16'h0001. Preload taken_cnt to 16'hFFFF via a directed-force helper task, then take another branch → taken_cnt stays at 16'hFFFF.
- Accept at edge k, rst asserted in cycle k+1 → no br_done and no flush afterward, flags all 0, br_ready=1 once rst is released.
